// File: rtl/fetch_instr_buffer_pkg.sv
// Shared configuration for the fetch-side instruction queue and its helpers.
package fetch_instr_buffer_pkg;

  // Core configuration fields used by the fetch path.
  typedef struct packed {
    int unsigned INSTR_PER_FETCH;
    int unsigned ILEN;
    int unsigned VLEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{INSTR_PER_FETCH: 32'd4, ILEN: 32'd32, VLEN: 32'd32};

  // Byte distance between consecutive fetch slots.
  localparam int unsigned FETCH_PC_STEP = 4;

  // Width of one {pc, instr} entry for a given configuration.
  function automatic int unsigned entry_width(cfg_t cfg);
    return cfg.VLEN + cfg.ILEN;
  endfunction

endpackage

// File: rtl/fetch_instr_buffer_compactor.sv
// Packs the valid slots of a fetch group to the low positions, tagging each with its PC.
module instr_compactor
  import fetch_instr_buffer_pkg::*;
#(
  parameter cfg_t Cfg = EmptyCfg
) (
  input  logic [Cfg.INSTR_PER_FETCH-1:0]                     mask_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0]            instrs_i,
  input  logic [Cfg.VLEN-1:0]                                pc_i,
  output logic [Cfg.INSTR_PER_FETCH*(Cfg.VLEN+Cfg.ILEN)-1:0] entries_o,
  output logic [$clog2(Cfg.INSTR_PER_FETCH+1)-1:0]           n_o
);

  localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN = Cfg.ILEN;
  localparam int unsigned VLEN = Cfg.VLEN;
  localparam int unsigned EW   = VLEN + ILEN;
  localparam int unsigned CW   = $clog2(IPF + 1);

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  fetch_entry_t entry;
  int unsigned  pos;

  // Walk slots in ascending order, dropping invalid ones; PC keeps the original slot offset.
  always_comb begin
    entries_o = '0;
    entry     = '0;
    pos       = 0;
    for (int unsigned k = 0; k < IPF; k++) begin
      if (mask_i[k]) begin
        entry.pc    = pc_i + VLEN'(FETCH_PC_STEP * k);
        entry.instr = instrs_i[k*ILEN +: ILEN];
        entries_o[pos*EW +: EW] = entry;
        pos = pos + 1;
      end
    end
    n_o = CW'(pos);
  end

endmodule

// File: rtl/fetch_instr_buffer.sv
// Circular instruction queue between fetch and decode with multi-slot enqueue and dequeue.
module fetch_instr_buffer
  import fetch_instr_buffer_pkg::*;
#(
  parameter cfg_t        Cfg       = EmptyCfg,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DEQ_WIDTH = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   fetch_valid_i,
  output logic                                   fetch_ready_o,
  input  logic [Cfg.VLEN-1:0]                    fetch_pc_i,
  input  logic [Cfg.INSTR_PER_FETCH*Cfg.ILEN-1:0] fetch_instrs_i,
  input  logic [Cfg.INSTR_PER_FETCH-1:0]         fetch_slot_valid_i,
  output logic [DEQ_WIDTH-1:0]                   deq_valid_o,
  output logic [DEQ_WIDTH*Cfg.ILEN-1:0]          deq_instr_o,
  output logic [DEQ_WIDTH*Cfg.VLEN-1:0]          deq_pc_o,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]         deq_count_i,
  output logic [$clog2(DEPTH+1)-1:0]             count_o
);

  localparam int unsigned IPF  = Cfg.INSTR_PER_FETCH;
  localparam int unsigned ILEN = Cfg.ILEN;
  localparam int unsigned VLEN = Cfg.VLEN;
  localparam int unsigned EW   = entry_width(Cfg);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam int unsigned CW   = $clog2(IPF + 1);

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Elaboration-time parameter sanity.
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_pow2
    $error("DEPTH must be a power of two");
  end
  if (DEPTH < 2 * IPF) begin : g_depth_min
    $error("DEPTH must hold at least two fetch groups");
  end
  if (DEQ_WIDTH < 1 || DEQ_WIDTH > DEPTH) begin : g_deq_range
    $error("DEQ_WIDTH must be in 1..DEPTH");
  end

  fetch_entry_t       mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]    count_q, count_d;

  logic [IPF*EW-1:0]  comp_entries;
  logic [CW-1:0]      comp_n;
  logic               enq_fire;
  logic [CNTW-1:0]    n_acc;
  logic [CNTW-1:0]    deq_req;
  logic [CNTW-1:0]    deq_amt;

  instr_compactor #(
    .Cfg (Cfg)
  ) u_compactor (
    .mask_i    (fetch_slot_valid_i),
    .instrs_i  (fetch_instrs_i),
    .pc_i      (fetch_pc_i),
    .entries_o (comp_entries),
    .n_o       (comp_n)
  );

  // Ready depends only on registered occupancy.
  assign fetch_ready_o = ((DEPTH - 32'(count_q)) >= IPF);
  assign enq_fire      = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign n_acc         = enq_fire ? CNTW'(comp_n) : '0;
  assign deq_req       = CNTW'(deq_count_i);
  assign deq_amt       = (deq_req < count_q) ? deq_req : count_q;
  assign count_o       = count_q;

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(deq_amt);
      wr_ptr_d = wr_ptr_q + PW'(n_acc);
      count_d  = count_q - deq_amt + n_acc;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < IPF; i++) begin
      if (enq_fire && (i < 32'(comp_n))) begin
        mem_q[wr_ptr_q + PW'(i)] <= comp_entries[i*EW +: EW];
      end
    end
  end

  // Oldest-first output lanes; lanes beyond occupancy read as zero.
  always_comb begin
    deq_valid_o = '0;
    deq_instr_o = '0;
    deq_pc_o    = '0;
    for (int unsigned j = 0; j < DEQ_WIDTH; j++) begin
      if (j < 32'(count_q)) begin
        deq_valid_o[j]            = 1'b1;
        deq_instr_o[j*ILEN +: ILEN] = mem_q[rd_ptr_q + PW'(j)].instr;
        deq_pc_o[j*VLEN +: VLEN]    = mem_q[rd_ptr_q + PW'(j)].pc;
      end
    end
  end

  // Simulation-time invariants.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (32'(count_q) <= DEPTH)
        else $error("occupancy exceeds DEPTH");
      assert (!(enq_fire && !fetch_ready_o))
        else $error("enqueue while not ready");
    end
  end

endmodule

// File: tb/tb_fetch_instr_buffer.sv
// Directed self-checking bench for fetch_instr_buffer (IPF=4, DEPTH=16, DEQ_WIDTH=4, 32-bit).
module tb_fetch_instr_buffer;
  import fetch_instr_buffer_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         flush_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  logic [31:0]  fetch_pc_i;
  logic [127:0] fetch_instrs_i;
  logic [3:0]   fetch_slot_valid_i;
  logic [3:0]   deq_valid_o;
  logic [127:0] deq_instr_o;
  logic [127:0] deq_pc_o;
  logic [2:0]   deq_count_i;
  logic [4:0]   count_o;

  int errors = 0;
  int checks = 0;

  fetch_instr_buffer #(
    .Cfg       (EmptyCfg),
    .DEPTH     (16),
    .DEQ_WIDTH (4)
  ) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_pc_i         (fetch_pc_i),
    .fetch_instrs_i     (fetch_instrs_i),
    .fetch_slot_valid_i (fetch_slot_valid_i),
    .deq_valid_o        (deq_valid_o),
    .deq_instr_o        (deq_instr_o),
    .deq_pc_o           (deq_pc_o),
    .deq_count_i        (deq_count_i),
    .count_o            (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i            = 1'b0;
    fetch_valid_i      = 1'b0;
    fetch_pc_i         = '0;
    fetch_instrs_i     = '0;
    fetch_slot_valid_i = '0;
    deq_count_i        = '0;
  endtask

  function automatic logic [3:0] therm(int c);
    logic [3:0] t;
    for (int j = 0; j < 4; j++) t[j] = (j < c);
    return t;
  endfunction

  task automatic offer(input logic [31:0] pc, input logic [31:0] base, input logic [3:0] mask);
    fetch_valid_i      = 1'b1;
    fetch_pc_i         = pc;
    fetch_slot_valid_i = mask;
    for (int k = 0; k < 4; k++) fetch_instrs_i[k*32 +: 32] = base + 32'(k);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #12;
    rst_ni = 1'b1;
    tick();
    tick();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_deq_valid got=%b exp=0000", deq_valid_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", fetch_ready_o); end
  endtask

  task automatic test_full_group();
    logic [31:0] exp_pc;
    offer(32'h8000_0000, 32'hA000_0000, 4'b1111);
    tick();
    idle_inputs();
    checks++; if (deq_valid_o !== 4'b1111) begin errors++; $display("FAIL full_deq_valid got=%b exp=1111", deq_valid_o); end
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count_o); end
    for (int j = 0; j < 4; j++) begin
      exp_pc = 32'h8000_0000 + 32'(4 * j);
      checks++; if (deq_pc_o[j*32 +: 32] !== exp_pc) begin errors++; $display("FAIL full_pc lane=%0d got=%h exp=%h", j, deq_pc_o[j*32 +: 32], exp_pc); end
      checks++; if (deq_instr_o[j*32 +: 32] !== 32'hA000_0000 + 32'(j)) begin errors++; $display("FAIL full_instr lane=%0d got=%h exp=%h", j, deq_instr_o[j*32 +: 32], 32'hA000_0000 + 32'(j)); end
    end
    deq_count_i = 3'd4;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL full_drain_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_sparse();
    offer(32'h0000_0100, 32'hB000_0000, 4'b1010);
    tick();
    idle_inputs();
    checks++; if (deq_valid_o !== 4'b0011) begin errors++; $display("FAIL sparse_deq_valid got=%b exp=0011", deq_valid_o); end
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL sparse_count got=%0d exp=2", count_o); end
    checks++; if (deq_instr_o[31:0] !== 32'hB000_0001) begin errors++; $display("FAIL sparse_instr0 got=%h exp=b0000001", deq_instr_o[31:0]); end
    checks++; if (deq_pc_o[31:0] !== 32'h0000_0104) begin errors++; $display("FAIL sparse_pc0 got=%h exp=00000104", deq_pc_o[31:0]); end
    checks++; if (deq_instr_o[63:32] !== 32'hB000_0003) begin errors++; $display("FAIL sparse_instr1 got=%h exp=b0000003", deq_instr_o[63:32]); end
    checks++; if (deq_pc_o[63:32] !== 32'h0000_010C) begin errors++; $display("FAIL sparse_pc1 got=%h exp=0000010c", deq_pc_o[63:32]); end
    checks++; if (deq_pc_o[127:64] !== 64'd0 || deq_instr_o[127:64] !== 64'd0) begin errors++; $display("FAIL sparse_unused_lanes pc=%h instr=%h exp=0", deq_pc_o[127:64], deq_instr_o[127:64]); end
    deq_count_i = 3'd2;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL sparse_drain_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_backpressure();
    for (int g = 0; g < 3; g++) begin
      offer(32'h3000 + 32'(16 * g), 32'h4000 + 32'(4 * g), 4'b1111);
      tick();
    end
    idle_inputs();
    checks++; if (count_o !== 5'd12) begin errors++; $display("FAIL bp_count12 got=%0d exp=12", count_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready12 got=%b exp=1", fetch_ready_o); end
    offer(32'h3030, 32'h400C, 4'b1111);
    tick();
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL bp_count16 got=%0d exp=16", count_o); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready16 got=%b exp=0", fetch_ready_o); end
    offer(32'h9990, 32'h9990, 4'b1111);
    tick();
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL bp_not_accepted got=%0d exp=16", count_o); end
    idle_inputs();
    deq_count_i = 3'd1;
    tick();
    checks++; if (count_o !== 5'd15) begin errors++; $display("FAIL bp_count15 got=%0d exp=15", count_o); end
    checks++; if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready15 got=%b exp=0", fetch_ready_o); end
    checks++; if (deq_pc_o[31:0] !== 32'h3004) begin errors++; $display("FAIL bp_head15 got=%h exp=00003004", deq_pc_o[31:0]); end
    deq_count_i = 3'd3;
    tick();
    checks++; if (count_o !== 5'd12) begin errors++; $display("FAIL bp_back12 got=%0d exp=12", count_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b exp=1", fetch_ready_o); end
    checks++; if (deq_pc_o[31:0] !== 32'h3010) begin errors++; $display("FAIL bp_head12 got=%h exp=00003010", deq_pc_o[31:0]); end
    deq_count_i = 3'd4;
    for (int c = 0; c < 3; c++) tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_wrap_clamp();
    int sent = 0;
    int rx = 0;
    int mcnt = 0;
    int consumed;
    int cycles = 0;
    logic mready;
    logic [31:0] exp_pc;
    while (rx < 40 && cycles < 200) begin
      cycles++;
      consumed = (mcnt < 3) ? mcnt : 3;
      mready = ((16 - mcnt) >= 4);
      checks++; if (count_o !== 5'(mcnt)) begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cycles, count_o, mcnt); end
      checks++; if (fetch_ready_o !== mready) begin errors++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cycles, fetch_ready_o, mready); end
      checks++; if (deq_valid_o !== therm(mcnt)) begin errors++; $display("FAIL wrap_deq_valid cyc=%0d got=%b exp=%b", cycles, deq_valid_o, therm(mcnt)); end
      for (int j = 0; j < consumed; j++) begin
        exp_pc = 32'h1000 + 32'(4 * (rx + j));
        checks++; if (deq_pc_o[j*32 +: 32] !== exp_pc || deq_instr_o[j*32 +: 32] !== 32'hC0DE_0000 + 32'(rx + j)) begin
          errors++; $display("FAIL wrap_lane idx=%0d pc=%h instr=%h exp_pc=%h exp_instr=%h", rx + j, deq_pc_o[j*32 +: 32], deq_instr_o[j*32 +: 32], exp_pc, 32'hC0DE_0000 + 32'(rx + j));
        end
      end
      rx = rx + consumed;
      deq_count_i = 3'd3;
      if (sent < 40 && mready) begin
        offer(32'h1000 + 32'(4 * sent), 32'hC0DE_0000 + 32'(sent), 4'b1111);
        sent = sent + 4;
        mcnt = mcnt - consumed + 4;
      end else begin
        fetch_valid_i = 1'b0;
        mcnt = mcnt - consumed;
      end
      tick();
    end
    idle_inputs();
    checks++; if (rx !== 40) begin errors++; $display("FAIL wrap_received got=%0d exp=40", rx); end
    offer(32'h7000, 32'h7000, 4'b0011);
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd2) begin errors++; $display("FAIL clamp_pre got=%0d exp=2", count_o); end
    deq_count_i = 3'd4;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL clamp_count got=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 4'b0000) begin errors++; $display("FAIL clamp_deq_valid got=%b exp=0000", deq_valid_o); end
  endtask

  task automatic test_flush();
    offer(32'h5000, 32'h5000, 4'b1111);
    tick();
    offer(32'h5010, 32'h5004, 4'b1111);
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd8) begin errors++; $display("FAIL flush_pre_count got=%0d exp=8", count_o); end
    flush_i = 1'b1;
    offer(32'hDEAD_0000, 32'hDEAD_0000, 4'b1111);
    deq_count_i = 3'd2;
    #1;
    checks++; if (deq_pc_o[31:0] !== 32'h5000) begin errors++; $display("FAIL flush_same_cycle_pc got=%h exp=00005000", deq_pc_o[31:0]); end
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 4'b0000) begin errors++; $display("FAIL flush_deq_valid got=%b exp=0000", deq_valid_o); end
    offer(32'h6000, 32'h6000, 4'b1111);
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd4) begin errors++; $display("FAIL post_flush_count got=%0d exp=4", count_o); end
    for (int j = 0; j < 4; j++) begin
      checks++; if (deq_pc_o[j*32 +: 32] !== 32'h6000 + 32'(4 * j) || deq_instr_o[j*32 +: 32] !== 32'h6000 + 32'(j)) begin
        errors++; $display("FAIL post_flush_lane lane=%0d pc=%h instr=%h exp_pc=%h exp_instr=%h", j, deq_pc_o[j*32 +: 32], deq_instr_o[j*32 +: 32], 32'h6000 + 32'(4 * j), 32'h6000 + 32'(j));
      end
    end
    deq_count_i = 3'd4;
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL post_flush_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_reset_mid_traffic();
    offer(32'h8800, 32'h8800, 4'b1111);
    tick();
    offer(32'h8810, 32'h8804, 4'b1111);
    tick();
    offer(32'h8820, 32'h8808, 4'b0001);
    tick();
    idle_inputs();
    checks++; if (count_o !== 5'd9) begin errors++; $display("FAIL mid_pre_count got=%0d exp=9", count_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL mid_reset_count got=%0d exp=0", count_o); end
    checks++; if (deq_valid_o !== 4'b0000) begin errors++; $display("FAIL mid_reset_deq_valid got=%b exp=0000", deq_valid_o); end
    checks++; if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", fetch_ready_o); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_sparse();
    test_backpressure();
    test_wrap_clamp();
    test_flush();
    test_reset_mid_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
